// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end for the 4-bit ALU function set.
// The accumulator is operand A. Division is iterative: four restoring steps, one
// quotient bit per cycle, on magnitudes, with the sign applied afterwards.
// Optional build macro ALU_SEQ_STICKY_EN adds a sticky overflow flag with a clear input.
module alu_cmd_sequencer #(
  parameter logic [3:0] ACC_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_overflow,
  output logic       rsp_zero,
  output logic       rsp_sign,
  output logic       rsp_parity,
  output logic [3:0] acc,
  output logic       busy
`ifdef ALU_SEQ_STICKY_EN
  ,
  input  logic       sticky_clr,
  output logic       sticky_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Even parity: high when the number of set bits is even.
  function automatic logic even_parity(input logic [3:0] v);
    return ~^v;
  endfunction

  state_t      state_q;
  logic [3:0]  acc_q;
  logic [3:0]  rsp_data_q;
  logic        rsp_carry_q;
  logic        rsp_overflow_q;
  logic        rsp_zero_q;
  logic        rsp_sign_q;
  logic        rsp_parity_q;

  // Division working registers
  logic [3:0]  dvd_q;   // dividend magnitude, shifted out MSB first
  logic [3:0]  dvs_q;   // divisor magnitude
  logic [3:0]  rem_q;   // partial remainder (always < divisor, so 4 bits suffice)
  logic [3:0]  quo_q;   // quotient magnitude, shifted in LSB first
  logic        neg_q;   // quotient must be negated at the end
  logic [1:0]  cnt_q;   // iteration index 0..3

  // Single-cycle datapath
  logic [4:0]  sum_s;
  logic [4:0]  diff_s;
  logic [7:0]  sprod_s;
  logic [7:0]  uprod_s;
  logic [3:0]  mag_a_s;
  logic [3:0]  mag_b_s;
  logic [3:0]  res_d;
  logic        carry_d;
  logic        ovf_d;
  logic        div_start_s;

  // Division step datapath
  logic [4:0]  rem_sh_s;
  logic [3:0]  rem_d;
  logic [3:0]  quo_d;
  logic [3:0]  dvd_d;
  logic [3:0]  div_res_s;

  // Response register load mux
  logic        fin_load_s;
  logic [3:0]  fin_res_s;
  logic        fin_carry_s;
  logic        fin_ovf_s;

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign acc          = acc_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_sign     = rsp_sign_q;
  assign rsp_parity   = rsp_parity_q;

  // Single-cycle result and flags from accumulator and the offered operand.
  always_comb begin
    sum_s       = {1'b0, acc_q} + {1'b0, cmd_data};
    diff_s      = {1'b0, acc_q} - {1'b0, cmd_data};
    sprod_s     = {{4{acc_q[3]}}, acc_q} * {{4{cmd_data[3]}}, cmd_data};
    uprod_s     = {4'h0, acc_q} * {4'h0, cmd_data};
    mag_a_s     = acc_q[3] ? (4'h0 - acc_q) : acc_q;
    mag_b_s     = cmd_data[3] ? (4'h0 - cmd_data) : cmd_data;
    res_d       = 4'h0;
    carry_d     = 1'b0;
    ovf_d       = 1'b0;
    div_start_s = 1'b0;
    if (cmd_load) begin
      res_d = cmd_data;
    end else begin
      case (cmd_op)
        3'd0: begin
          res_d   = sum_s[3:0];
          carry_d = sum_s[4];
          ovf_d   = (acc_q[3] == cmd_data[3]) && (sum_s[3] != acc_q[3]);
        end
        3'd1: begin
          res_d   = diff_s[3:0];
          carry_d = diff_s[4];
          ovf_d   = (acc_q[3] != cmd_data[3]) && (diff_s[3] != acc_q[3]);
        end
        3'd2: begin
          res_d   = sprod_s[3:0];
          carry_d = (uprod_s > 8'd15);
          // Product fits in 4 signed bits only if bits 7..3 are all equal.
          ovf_d   = (sprod_s[7:3] != 5'b00000) && (sprod_s[7:3] != 5'b11111);
        end
        3'd3: begin
          if (cmd_data == 4'h0) begin
            res_d = 4'h0;
            ovf_d = 1'b1;
          end else if ((acc_q == 4'h8) && (cmd_data == 4'hF)) begin
            res_d = 4'h8;
            ovf_d = 1'b1;
          end else begin
            div_start_s = 1'b1;
          end
        end
        3'd4:    res_d = acc_q & cmd_data;
        3'd5:    res_d = acc_q | cmd_data;
        3'd6:    res_d = acc_q ^ cmd_data;
        3'd7:    res_d = ~acc_q;
        default: res_d = 4'h0;
      endcase
    end
  end

  // One restoring division step on the working registers.
  always_comb begin
    rem_sh_s = {rem_q, dvd_q[3]};
    if (rem_sh_s >= {1'b0, dvs_q}) begin
      rem_d = rem_sh_s[3:0] - dvs_q;
      quo_d = {quo_q[2:0], 1'b1};
    end else begin
      rem_d = rem_sh_s[3:0];
      quo_d = {quo_q[2:0], 1'b0};
    end
    dvd_d     = {dvd_q[2:0], 1'b0};
    div_res_s = neg_q ? (4'h0 - quo_d) : quo_d;
  end

  // Select what gets registered into the response on entry to RESP.
  always_comb begin
    fin_load_s  = 1'b0;
    fin_res_s   = 4'h0;
    fin_carry_s = 1'b0;
    fin_ovf_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && !div_start_s) begin
          fin_load_s  = 1'b1;
          fin_res_s   = res_d;
          fin_carry_s = carry_d;
          fin_ovf_s   = ovf_d;
        end else begin
          fin_load_s  = 1'b0;
        end
      end
      DIV: begin
        if (cnt_q == 2'd3) begin
          fin_load_s = 1'b1;
          fin_res_s  = div_res_s;
        end else begin
          fin_load_s = 1'b0;
        end
      end
      default: fin_load_s = 1'b0;
    endcase
  end

  // Control FSM with registered response, accumulator and divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= ACC_RESET;
      rsp_data_q     <= 4'h0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_sign_q     <= 1'b0;
      rsp_parity_q   <= 1'b0;
      dvd_q          <= 4'h0;
      dvs_q          <= 4'h0;
      rem_q          <= 4'h0;
      quo_q          <= 4'h0;
      neg_q          <= 1'b0;
      cnt_q          <= 2'd0;
    end else begin
      if (fin_load_s) begin
        rsp_data_q     <= fin_res_s;
        rsp_carry_q    <= fin_carry_s;
        rsp_overflow_q <= fin_ovf_s;
        rsp_zero_q     <= (fin_res_s == 4'h0);
        rsp_sign_q     <= fin_res_s[3];
        rsp_parity_q   <= even_parity(fin_res_s);
        acc_q          <= fin_res_s;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (div_start_s) begin
              dvd_q   <= mag_a_s;
              dvs_q   <= mag_b_s;
              rem_q   <= 4'h0;
              quo_q   <= 4'h0;
              neg_q   <= acc_q[3] ^ cmd_data[3];
              cnt_q   <= 2'd0;
              state_q <= DIV;
            end else begin
              state_q <= RESP;
            end
          end
        end
        DIV: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  logic sticky_q;
  assign sticky_ovf = sticky_q;

  // Sticky overflow: set by any overflowing response, set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (fin_load_s && fin_ovf_s) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with hand-computed expected values.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_overflow;
  logic       rsp_zero;
  logic       rsp_sign;
  logic       rsp_parity;
  logic [3:0] acc;
  logic       busy;
`ifdef ALU_SEQ_STICKY_EN
  logic       sticky_clr = 1'b0;
  logic       sticky_ovf;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  logic busy_ok;
  logic seen_valid;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.ACC_RESET(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_sign(rsp_sign), .rsp_parity(rsp_parity), .acc(acc), .busy(busy)
`ifdef ALU_SEQ_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command, wait for its response; lat = edges from accept to rsp_valid.
  task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] d,
                      output int l, output logic bok);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("cmd_ready_before_send", {7'h00, cmd_ready}, 8'h01);
    cmd_load = ld; cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Scramble command inputs: they must be ignored after accept.
    cmd_data = ~d; cmd_op = ~op; cmd_load = ~ld;
    l = 1;
    bok = 1'b1;
    while (!rsp_valid && l < 20) begin
      if (!busy || cmd_ready) bok = 1'b0;
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_handshake", {7'h00, rsp_valid}, 8'h00);
  endtask

  // flags = {carry, overflow, zero, sign, parity}
  task automatic chk_rsp(input string tag, input logic [3:0] d, input logic [4:0] flags);
    check({tag, "_valid"}, {7'h00, rsp_valid}, 8'h01);
    check({tag, "_data"}, {4'h0, rsp_data}, {4'h0, d});
    check({tag, "_flags"}, {3'h0, rsp_carry, rsp_overflow, rsp_zero, rsp_sign, rsp_parity},
          {3'h0, flags});
    check({tag, "_acc"}, {4'h0, acc}, {4'h0, d});
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0;
    cmd_data = 4'h0; rsp_ready = 1'b0;
    #12;
    check("rst_cmd_ready", {7'h00, cmd_ready}, 8'h01);
    check("rst_rsp_valid", {7'h00, rsp_valid}, 8'h00);
    check("rst_busy", {7'h00, busy}, 8'h00);
    check("rst_acc", {4'h0, acc}, 8'h00);
    check("rst_rsp", {rsp_data, 1'b0, rsp_carry, rsp_overflow, rsp_zero}, 8'h00);
    check("rst_rsp2", {6'h00, rsp_sign, rsp_parity}, 8'h00);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load 3, add 5 -> 8 with signed overflow
    send(1'b1, 3'd0, 4'h3, lat, busy_ok);
    check("load3_lat", lat[7:0], 8'd1);
    chk_rsp("load3", 4'h3, 5'b00001);
    consume();
    send(1'b0, 3'd0, 4'h5, lat, busy_ok);
    check("add_lat", lat[7:0], 8'd1);
    chk_rsp("add", 4'h8, 5'b01010);
    consume();

    // Load 2, sub 3 -> F with borrow
    send(1'b1, 3'd0, 4'h2, lat, busy_ok); consume();
    send(1'b0, 3'd1, 4'h3, lat, busy_ok);
    chk_rsp("sub", 4'hF, 5'b10011);
    consume();

    // Load -3, mul 3 -> -9 truncates to 7
    send(1'b1, 3'd0, 4'hD, lat, busy_ok); consume();
    send(1'b0, 3'd2, 4'h3, lat, busy_ok);
    chk_rsp("mul", 4'h7, 5'b11000);
    consume();

    // Load -7, div 2 -> -3, iterative
    send(1'b1, 3'd0, 4'h9, lat, busy_ok); consume();
    send(1'b0, 3'd3, 4'h2, lat, busy_ok);
    check("div_lat", lat[7:0], 8'd5);
    check("div_busy", {7'h00, busy_ok}, 8'h01);
    chk_rsp("div", 4'hD, 5'b00010);
    consume();

    // Divide by zero (acc = -3)
    send(1'b0, 3'd3, 4'h0, lat, busy_ok);
    check("div0_lat", lat[7:0], 8'd1);
    chk_rsp("div0", 4'h0, 5'b01101);
    consume();

    // -8 / -1 overflow case
    send(1'b1, 3'd0, 4'h8, lat, busy_ok); consume();
    send(1'b0, 3'd3, 4'hF, lat, busy_ok);
    check("divovf_lat", lat[7:0], 8'd1);
    chk_rsp("divovf", 4'h8, 5'b01010);
    consume();

    // -8 / 2 -> -4 ; 6 / -4 -> -1
    send(1'b0, 3'd3, 4'h2, lat, busy_ok);
    check("div_m8_lat", lat[7:0], 8'd5);
    chk_rsp("div_m8", 4'hC, 5'b00011);
    consume();
    send(1'b1, 3'd0, 4'h6, lat, busy_ok); consume();
    send(1'b0, 3'd3, 4'hC, lat, busy_ok);
    chk_rsp("div_neg", 4'hF, 5'b00011);
    consume();

    // Logic ops: 5 and 3 -> 1 ; or C -> D ; xor 7 -> A ; not -> 5
    send(1'b1, 3'd0, 4'h5, lat, busy_ok); consume();
    send(1'b0, 3'd4, 4'h3, lat, busy_ok);
    chk_rsp("and", 4'h1, 5'b00000);
    consume();
    send(1'b0, 3'd5, 4'hC, lat, busy_ok);
    chk_rsp("or", 4'hD, 5'b00010);
    consume();
    send(1'b0, 3'd6, 4'h7, lat, busy_ok);
    chk_rsp("xor", 4'hA, 5'b00011);
    consume();
    send(1'b0, 3'd7, 4'h0, lat, busy_ok);
    chk_rsp("not", 4'h5, 5'b00001);
    consume();

    // Backpressure: 5 + 1 = 6, held for three cycles while a command is offered
    send(1'b0, 3'd0, 4'h1, lat, busy_ok);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'h9;
      @(posedge clk); #1;
      check("bp_valid", {7'h00, rsp_valid}, 8'h01);
      check("bp_data", {4'h0, rsp_data}, 8'h06);
      check("bp_cmd_ready", {7'h00, cmd_ready}, 8'h00);
    end
    cmd_valid = 1'b0;
    consume();
    check("bp_acc", {4'h0, acc}, 8'h06);

    // Reset mid-division
    send(1'b1, 3'd0, 4'h7, lat, busy_ok); consume();
    cmd_load = 1'b0; cmd_op = 3'd3; cmd_data = 4'h2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("middiv_busy", {7'h00, busy}, 8'h01);
    rst_n = 1'b0;
    #2;
    check("middiv_rst_acc", {4'h0, acc}, 8'h00);
    check("middiv_rst_busy", {7'h00, busy}, 8'h00);
    #4 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("middiv_no_rsp", {7'h00, seen_valid}, 8'h00);
    check("middiv_cmd_ready", {7'h00, cmd_ready}, 8'h01);
    check("middiv_acc_hold", {4'h0, acc}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
